// File: rtl/conware_gen_ctrl_if.sv
// AXI4-Stream bundle shared by the conware generation sequencer and its bench.
// The monitor modport is a passive tap that only observes a handshake.
interface conware_gen_ctrl_if #(
   parameter int DWIDTH = 32
) ();
   logic              tvalid;
   logic              tready;
   logic [DWIDTH-1:0] tdata;
   logic              tlast;

   modport master  (output tvalid, tdata, tlast, input tready);
   modport slave   (input tvalid, tdata, tlast, output tready);
   modport monitor (input tvalid, tready, tlast);
endinterface

// File: rtl/conware_gen_ctrl.sv
// Generation sequencer for the conware Life engine: admits one frame per generation,
// watches the engine output for completion and counts generations. Watchdog: CONWARE_CTRL_TIMEOUT_EN.
module conware_gen_ctrl #(
   parameter int DWIDTH  = 32,
   parameter int WIDTH   = 8,
   parameter int HEIGHT  = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic                      cfg_start,
   input  logic                      cfg_abort,
   input  logic [15:0]               cfg_gens,
   output logic                      status_busy,
   output logic                      status_done,
   output logic [15:0]               status_gen,
   output logic                      status_err,
   output logic                      irq,
   conware_gen_ctrl_if.slave         s_axis,
   conware_gen_ctrl_if.master        c_axis,
   conware_gen_ctrl_if.monitor       r_axis
);

   localparam int FRAME_BEATS = WIDTH * HEIGHT;
   localparam int CW          = $clog2(FRAME_BEATS + 1);
   localparam logic [CW-1:0] FULL = CW'(FRAME_BEATS);
   localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);

   typedef enum logic [1:0] {IDLE, RUN, NEXT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     in_cnt;
   logic [CW-1:0]     out_cnt;
   logic [15:0]       gens_q;
   logic [DWIDTH-1:0] data;
   logic              in_en;
   logic              in_beat;
   logic              r_hs;
   logic              out_beat;
   logic              frame_done;
   logic              last_gen;
   logic              timeout_hit;

   // Zero-latency gating: the frame passes straight through while a slot is open.
   assign in_en         = (state == RUN) && (in_cnt != FULL);
   assign data          = s_axis.tdata;
   assign c_axis.tdata  = data;
   assign c_axis.tvalid = s_axis.tvalid & in_en;
   assign c_axis.tlast  = (in_cnt == LAST);
   assign s_axis.tready = c_axis.tready & in_en;

   assign in_beat    = s_axis.tvalid & s_axis.tready;
   assign r_hs       = (state == RUN) & r_axis.tvalid & r_axis.tready;
   assign out_beat   = r_hs & (out_cnt != FULL);
   assign frame_done = (in_cnt == FULL) && (out_cnt == FULL);
   assign last_gen   = ((status_gen + 16'd1) == gens_q);

   assign status_busy = (state == RUN) || (state == NEXT);

`ifdef CONWARE_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_cnt;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wd_cnt <= '0;
      end else if ((state != RUN) || in_beat || r_hs) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Fires on the TIMEOUT-th consecutive cycle in RUN without any beat.
   assign timeout_hit = (state == RUN) && !in_beat && !r_hs && (wd_cnt == TW'(TIMEOUT - 1));
`else
   // No watchdog: RUN waits indefinitely for the engine.
   assign timeout_hit = 1'b0 && (TIMEOUT != 0);
`endif

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
      state_nxt = state;
      if (cfg_abort || timeout_hit) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (cfg_start) state_nxt = (cfg_gens != 16'd0) ? RUN : DONE;
            RUN:  if (frame_done) state_nxt = NEXT;
            NEXT: state_nxt = last_gen ? DONE : RUN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         in_cnt      <= '0;
         out_cnt     <= '0;
         gens_q      <= '0;
         status_gen  <= '0;
         status_done <= 1'b0;
         status_err  <= 1'b0;
         irq         <= 1'b0;
      end else begin
         irq <= 1'b0;
         if (cfg_abort) begin
            in_cnt  <= '0;
            out_cnt <= '0;
         end else if (timeout_hit) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            status_err <= 1'b1;
            irq        <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (cfg_start) begin
                     gens_q      <= cfg_gens;
                     status_gen  <= '0;
                     status_done <= 1'b0;
                     status_err  <= 1'b0;
                     in_cnt      <= '0;
                     out_cnt     <= '0;
                  end
               end
               RUN: begin
                  if (in_beat) begin
                     in_cnt <= in_cnt + 1'b1;
                     // Framing follows the count; a misplaced TLAST is only flagged.
                     if (s_axis.tlast != (in_cnt == LAST)) status_err <= 1'b1;
                  end
                  if (out_beat) begin
                     out_cnt <= out_cnt + 1'b1;
                     if (r_axis.tlast != (out_cnt == LAST)) status_err <= 1'b1;
                  end
               end
               NEXT: begin
                  status_gen <= status_gen + 16'd1;
                  in_cnt     <= '0;
                  out_cnt    <= '0;
               end
               DONE: begin
                  irq         <= 1'b1;
                  status_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conware_gen_ctrl.sv
// Directed bench for conware_gen_ctrl (WIDTH=8, HEIGHT=1, TIMEOUT=16).
// Honours CONWARE_CTRL_TIMEOUT_EN for the stalled-engine case.
module tb_conware_gen_ctrl;

   localparam logic [31:0] BASE = 32'hC0DE_0000;

   logic        clk;
   logic        rst_n;
   logic        cfg_start;
   logic        cfg_abort;
   logic [15:0] cfg_gens;
   logic        status_busy;
   logic        status_done;
   logic [15:0] status_gen;
   logic        status_err;
   logic        irq;

   conware_gen_ctrl_if #(.DWIDTH(32)) s_if ();
   conware_gen_ctrl_if #(.DWIDTH(32)) c_if ();
   conware_gen_ctrl_if #(.DWIDTH(32)) r_if ();

   conware_gen_ctrl #(
      .DWIDTH (32),
      .WIDTH  (8),
      .HEIGHT (1),
      .TIMEOUT(16)
   ) dut (
      .ACLK       (clk),
      .ARESETN    (rst_n),
      .cfg_start  (cfg_start),
      .cfg_abort  (cfg_abort),
      .cfg_gens   (cfg_gens),
      .status_busy(status_busy),
      .status_done(status_done),
      .status_gen (status_gen),
      .status_err (status_err),
      .irq        (irq),
      .s_axis     (s_if),
      .c_axis     (c_if),
      .r_axis     (r_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Results of the last drive_run call.
   int fwd_cnt;
   int r_sent;
   int irq_cnt;
   int tlast_bad;
   int data_bad;
   int stall_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] gens);
      cfg_gens  = gens;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   // Streams n_src source beats and plays the engine: it echoes one output beat per
   // forwarded beat (stopping after r_stop), with optional bad TLAST on 1-based beats.
   task automatic drive_run(input int n_src, input int bad_s, input int bad_r,
                            input bit toggle, input int r_stop, input int max_cyc);
      int src_idx = 0;
      int tail    = 0;
      fwd_cnt   = 0;
      r_sent    = 0;
      irq_cnt   = 0;
      tlast_bad = 0;
      data_bad  = 0;
      stall_bad = 0;
      r_if.tready = 1'b1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         s_if.tvalid = (src_idx < n_src);
         s_if.tdata  = BASE + 32'(src_idx);
         s_if.tlast  = ((src_idx % 8) == 7) ^ (src_idx == bad_s - 1);
         c_if.tready = toggle ? ((cyc % 2) == 0) : 1'b1;
         r_if.tvalid = (r_sent < fwd_cnt) && (r_sent < r_stop);
         r_if.tlast  = ((r_sent % 8) == 7) ^ (r_sent == bad_r - 1);
         #3;
         if (irq) irq_cnt++;
         if ((fwd_cnt / 8) > int'(status_gen) && s_if.tready) stall_bad++;
         if (c_if.tvalid && c_if.tready) begin
            if (c_if.tlast != ((fwd_cnt % 8) == 7)) tlast_bad++;
            if (c_if.tdata != BASE + 32'(fwd_cnt)) data_bad++;
            fwd_cnt++;
         end
         if (s_if.tvalid && s_if.tready) src_idx++;
         if (r_if.tvalid && r_if.tready) r_sent++;
         step();
         if (irq_cnt > 0) tail++;
         if (tail == 4) break;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      r_if.tvalid = 1'b0;
      r_if.tlast  = 1'b0;
      c_if.tready = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      cfg_start   = 1'b0;
      cfg_abort   = 1'b0;
      cfg_gens    = '0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = BASE;
      s_if.tlast  = 1'b0;
      c_if.tready = 1'b1;
      r_if.tvalid = 1'b0;
      r_if.tready = 1'b0;
      r_if.tlast  = 1'b0;
      r_if.tdata  = '0;

      // Reset: everything quiet, offered beats stalled.
      repeat (3) step();
      check("rst_busy",   32'(status_busy), 32'd0);
      check("rst_done",   32'(status_done), 32'd0);
      check("rst_gen",    32'(status_gen),  32'd0);
      check("rst_err",    32'(status_err),  32'd0);
      check("rst_irq",    32'(irq),         32'd0);
      check("rst_sready", 32'(s_if.tready), 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_sready", 32'(s_if.tready), 32'd0);
      check("idle_cvalid", 32'(c_if.tvalid), 32'd0);
      s_if.tvalid = 1'b0;

      // 1: single generation.
      start_run(16'd1);
      check("t1_busy", 32'(status_busy), 32'd1);
      drive_run(8, 0, 0, 1'b0, 1000, 100);
      check("t1_fwd",   32'(fwd_cnt),    32'd8);
      check("t1_tlast", 32'(tlast_bad),  32'd0);
      check("t1_data",  32'(data_bad),   32'd0);
      check("t1_irq",   32'(irq_cnt),    32'd1);
      check("t1_done",  32'(status_done),32'd1);
      check("t1_gen",   32'(status_gen), 32'd1);
      check("t1_err",   32'(status_err), 32'd0);
      check("t1_busy_end", 32'(status_busy), 32'd0);

      // 2: three generations, toggling downstream ready, surplus source beats.
      start_run(16'd3);
      drive_run(30, 0, 0, 1'b1, 1000, 200);
      check("t2_fwd",   32'(fwd_cnt),    32'd24);
      check("t2_gen",   32'(status_gen), 32'd3);
      check("t2_irq",   32'(irq_cnt),    32'd1);
      check("t2_stall", 32'(stall_bad),  32'd0);
      check("t2_tlast", 32'(tlast_bad),  32'd0);
      check("t2_err",   32'(status_err), 32'd0);

      // 3: zero generations goes straight to DONE.
      start_run(16'd0);
      check("t3_busy0", 32'(status_busy), 32'd0);
      check("t3_irq0",  32'(irq),         32'd0);
      check("t3_done0", 32'(status_done), 32'd0);
      step();
      check("t3_irq1",  32'(irq),         32'd1);
      check("t3_done1", 32'(status_done), 32'd1);
      check("t3_gen",   32'(status_gen),  32'd0);
      check("t3_busy1", 32'(status_busy), 32'd0);
      step();
      check("t3_irq2",  32'(irq),         32'd0);

      // 4: abort after four input beats, then a clean restart.
      start_run(16'd2);
      c_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = BASE + 32'(i);
         s_if.tlast  = 1'b0;
         step();
      end
      s_if.tvalid = 1'b0;
      cfg_abort   = 1'b1;
      step();
      cfg_abort   = 1'b0;
      s_if.tvalid = 1'b1;
      #1;
      check("t4_busy",   32'(status_busy), 32'd0);
      check("t4_sready", 32'(s_if.tready), 32'd0);
      check("t4_done",   32'(status_done), 32'd0);
      check("t4_gen",    32'(status_gen),  32'd0);
      s_if.tvalid = 1'b0;
      step();
      cfg_abort = 1'b1;
      start_run(16'd1);
      cfg_abort = 1'b0;
      check("t4_abort_wins", 32'(status_busy), 32'd0);
      start_run(16'd1);
      drive_run(8, 0, 0, 1'b0, 1000, 100);
      check("t4_fwd",   32'(fwd_cnt),    32'd8);
      check("t4_tlast", 32'(tlast_bad),  32'd0);
      check("t4_gen",   32'(status_gen), 32'd1);
      check("t4_done2", 32'(status_done),32'd1);

      // 5: early S_TLAST on beat 5 is flagged but framing follows the count.
      start_run(16'd1);
      drive_run(8, 5, 0, 1'b0, 1000, 100);
      check("t5_fwd",   32'(fwd_cnt),    32'd8);
      check("t5_tlast", 32'(tlast_bad),  32'd0);
      check("t5_err",   32'(status_err), 32'd1);
      check("t5_done",  32'(status_done),32'd1);
      check("t5_gen",   32'(status_gen), 32'd1);

      // 5b: early R_TLAST on output beat 3.
      start_run(16'd1);
      check("t5b_err_clr", 32'(status_err), 32'd0);
      drive_run(8, 0, 3, 1'b0, 1000, 100);
      check("t5b_err",  32'(status_err), 32'd1);
      check("t5b_done", 32'(status_done),32'd1);

      // 6: engine output stalls after three beats.
      start_run(16'd1);
      drive_run(8, 0, 0, 1'b0, 3, 60);
`ifdef CONWARE_CTRL_TIMEOUT_EN
      check("t6_err",  32'(status_err),  32'd1);
      check("t6_busy", 32'(status_busy), 32'd0);
      check("t6_irq",  32'(irq_cnt),     32'd1);
      check("t6_done", 32'(status_done), 32'd0);
`else
      check("t6_err",   32'(status_err),  32'd0);
      check("t6_busy",  32'(status_busy), 32'd1);
      check("t6_irq",   32'(irq_cnt),     32'd0);
      check("t6_stall", 32'(stall_bad),   32'd0);
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0;
      check("t6_abort_busy", 32'(status_busy), 32'd0);
      check("t6_abort_done", 32'(status_done), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
